// File: rtl/i2c_master_word_ctrl.sv
// Byte/word-level I2C master controller: sequences START, data bits, ACK and STOP
// commands towards a bit-level controller and collects read data and the slave ACK.
module i2c_master_word_ctrl #(
    parameter int DW = 8,
    parameter int CW = 5
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Cmd_valid,
    output logic          Cmd_ready,
    input  logic          Start,
    input  logic          Stop,
    input  logic          Read,
    input  logic          Write,
    input  logic          Tx_ack,
    input  logic [DW-1:0] Din,
    output logic [3:0]    Bit_cmd,
    output logic          Bit_txd,
    input  logic          Bit_ack,
    input  logic          Bit_rxd,
    input  logic          I2C_al,
    output logic [DW-1:0] Dout,
    output logic          Rx_ack,
    output logic          I2C_done,
    output logic          Busy,
    output logic          Al
);

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WRITE, S_READ, S_ACK, S_STOP, S_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic          start_reg, start_next;
    logic          stop_reg, stop_next;
    logic          read_reg, read_next;
    logic          write_reg, write_next;
    logic          tx_ack_reg, tx_ack_next;
    logic [DW-1:0] sr_reg, sr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    bit_cmd_reg, bit_cmd_next;
    logic          bit_txd_reg, bit_txd_next;
    logic [DW-1:0] dout_reg, dout_next;
    logic          rx_ack_reg, rx_ack_next;
    logic          done_reg, done_next;
    logic          al_reg, al_next;
    logic [DW-1:0] sr_shl;
    logic [DW-1:0] sr_shin;

    // First remaining phase given which command fields are still pending.
    function automatic state_t phase_from(input logic s, input logic w, input logic r, input logic p);
        if (s)      return S_START;
        else if (w) return S_WRITE;
        else if (r) return S_READ;
        else if (p) return S_STOP;
        else        return S_DONE;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign sr_shl[gi]  = 1'b0;
                assign sr_shin[gi] = Bit_rxd;
            end else begin : g_upper
                assign sr_shl[gi]  = sr_reg[gi-1];
                assign sr_shin[gi] = sr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg   <= S_IDLE;
            start_reg   <= 1'b0;
            stop_reg    <= 1'b0;
            read_reg    <= 1'b0;
            write_reg   <= 1'b0;
            tx_ack_reg  <= 1'b0;
            sr_reg      <= '0;
            cnt_reg     <= '0;
            bit_cmd_reg <= CMD_NOP;
            bit_txd_reg <= 1'b0;
            dout_reg    <= '0;
            rx_ack_reg  <= 1'b0;
            done_reg    <= 1'b0;
            al_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            start_reg   <= start_next;
            stop_reg    <= stop_next;
            read_reg    <= read_next;
            write_reg   <= write_next;
            tx_ack_reg  <= tx_ack_next;
            sr_reg      <= sr_next;
            cnt_reg     <= cnt_next;
            bit_cmd_reg <= bit_cmd_next;
            bit_txd_reg <= bit_txd_next;
            dout_reg    <= dout_next;
            rx_ack_reg  <= rx_ack_next;
            done_reg    <= done_next;
            al_reg      <= al_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_next  = start_reg;
        stop_next   = stop_reg;
        read_next   = read_reg;
        write_next  = write_reg;
        tx_ack_next = tx_ack_reg;
        sr_next     = sr_reg;
        cnt_next    = cnt_reg;
        dout_next   = dout_reg;
        rx_ack_next = rx_ack_reg;
        al_next     = al_reg;

        case (state_reg)
            S_IDLE: begin
                if (Cmd_valid) begin
                    start_next  = Start;
                    stop_next   = Stop;
                    read_next   = Read;
                    write_next  = Write;
                    tx_ack_next = Tx_ack;
                    sr_next     = Din;
                    cnt_next    = CW'(DW - 1);
                    al_next     = 1'b0;
                    state_next  = phase_from(Start, Write, Read, Stop);
                end
            end
            S_START: begin
                if (Bit_ack) state_next = phase_from(1'b0, write_reg, read_reg, stop_reg);
            end
            S_WRITE, S_READ: begin
                if (Bit_ack) begin
                    sr_next  = (state_reg == S_WRITE) ? sr_shl : sr_shin;
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == '0) state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (Bit_ack) begin
                    if (write_reg) rx_ack_next = Bit_rxd;
                    else           dout_next   = sr_reg;
                    state_next = phase_from(1'b0, 1'b0, 1'b0, stop_reg);
                end
            end
            S_STOP: begin
                if (Bit_ack) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Arbitration loss aborts the frame and wins over a coincident Bit_ack.
        if (I2C_al && state_reg != S_IDLE) begin
            al_next     = 1'b1;
            dout_next   = dout_reg;
            rx_ack_next = rx_ack_reg;
            if (state_reg != S_DONE) state_next = S_DONE;
        end

        bit_cmd_next = CMD_NOP;
        bit_txd_next = 1'b0;
        case (state_next)
            S_START: bit_cmd_next = CMD_START;
            S_WRITE: begin
                bit_cmd_next = CMD_WRITE;
                bit_txd_next = sr_next[DW-1];
            end
            S_READ:  bit_cmd_next = CMD_READ;
            S_ACK: begin
                bit_cmd_next = write_next ? CMD_READ : CMD_WRITE;
                bit_txd_next = write_next ? 1'b0 : tx_ack_next;
            end
            S_STOP:  bit_cmd_next = CMD_STOP;
            default: bit_cmd_next = CMD_NOP;
        endcase
        done_next = (state_next == S_DONE);
    end

    assign Cmd_ready = (state_reg == S_IDLE);
    assign Busy      = (state_reg != S_IDLE);
    assign Bit_cmd   = bit_cmd_reg;
    assign Bit_txd   = bit_txd_reg;
    assign Dout      = dout_reg;
    assign Rx_ack    = rx_ack_reg;
    assign I2C_done  = done_reg;
    assign Al        = al_reg;

endmodule
